// File: rtl/boot_seq.sv
// boot_seq: qualifies a warm-boot request, detaches from USB, then drives SB_WARMBOOT
// with a stable image select before asserting BOOT.
module boot_seq #(
   parameter int CLK_PERIODS_PER_US = 16,
   parameter int QUAL_CYCLES        = 4,
   parameter int DETACH_US          = 10000,
   parameter int SEL_SETUP_CYCLES   = 4
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       boot_i,
   input  logic [1:0] image_sel_i,
   output logic       busy_o,
   output logic       usb_detach_o,
   output logic [1:0] warmboot_s_o,
   output logic       warmboot_boot_o
);
   localparam int DT   = DETACH_US * CLK_PERIODS_PER_US;
   localparam int TMAX = DT > SEL_SETUP_CYCLES ? DT : SEL_SETUP_CYCLES;
   localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
   localparam int QW   = $clog2(QUAL_CYCLES + 1);

   typedef enum logic [2:0] {ST_IDLE, ST_QUAL, ST_DETACH, ST_SETUP, ST_BOOT} state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   qual_cnt_q, qual_cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [1:0]      sel_q, sel_d, s_q, s_d;
   logic            busy_q, busy_d, detach_q, detach_d, wb_boot_q, wb_boot_d;

   always_comb begin
      state_d    = state_q;
      qual_cnt_d = boot_i ? qual_cnt_q : '0;
      timer_d    = timer_q;
      sel_d      = sel_q;
      case (state_q)
         ST_IDLE, ST_QUAL: begin
            if (boot_i) begin
               qual_cnt_d = qual_cnt_q + QW'(1);
               if (qual_cnt_q == QW'(QUAL_CYCLES - 1)) begin
                  state_d = ST_DETACH;
                  sel_d   = image_sel_i;
                  timer_d = TW'(DT - 1);
               end else begin
                  state_d = ST_QUAL;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DETACH: begin
            if (timer_q == '0) begin
               state_d = ST_SETUP;
               timer_d = TW'(SEL_SETUP_CYCLES - 1);
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         ST_SETUP: begin
            if (timer_q == '0) state_d = ST_BOOT;
            else timer_d = timer_q - TW'(1);
         end
         ST_BOOT: state_d = ST_BOOT;
         default: begin
            state_d    = ST_IDLE;
            qual_cnt_d = '0;
            timer_d    = '0;
            sel_d      = '0;
         end
      endcase
      // outputs are decoded from the next state so they register alongside it
      busy_d    = state_d == ST_DETACH || state_d == ST_SETUP || state_d == ST_BOOT;
      detach_d  = busy_d;
      s_d       = (state_d == ST_SETUP || state_d == ST_BOOT) ? sel_d : 2'b00;
      wb_boot_d = state_d == ST_BOOT;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         qual_cnt_q <= '0;
         timer_q    <= '0;
         sel_q      <= '0;
         busy_q     <= 1'b0;
         detach_q   <= 1'b0;
         s_q        <= 2'b00;
         wb_boot_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         qual_cnt_q <= qual_cnt_d;
         timer_q    <= timer_d;
         sel_q      <= sel_d;
         busy_q     <= busy_d;
         detach_q   <= detach_d;
         s_q        <= s_d;
         wb_boot_q  <= wb_boot_d;
      end
   end

   assign busy_o          = busy_q;
   assign usb_detach_o    = detach_q;
   assign warmboot_s_o    = s_q;
   assign warmboot_boot_o = wb_boot_q;
endmodule

// File: tb/tb_boot_seq.sv
// tb_boot_seq: directed scenarios push expected output transitions into queues; monitors
// pop and compare whenever an output vector {busy, detach, s[1:0], boot} changes.
module tb_boot_seq;
   logic       clk = 1'b0;
   logic       rstn_i = 1'b1;
   logic       boot_i = 1'b0, boot1_i = 1'b0;
   logic [1:0] image_sel_i = 2'b00;
   logic       busy0, det0, wb0, busy1, det1, wb1;
   logic [1:0] s0, s1;

   typedef struct { int e; logic [4:0] v; } ev_t;
   ev_t        q0[$], q1[$];
   ev_t        ev0, ev1;
   logic [4:0] prev0 = '0, prev1 = '0, cur0, cur1;
   bit         mon_en = 1'b0;
   int         edge_n = 0;
   int         n_cmp = 0, n_bad = 0;
   int         e;

   boot_seq #(.CLK_PERIODS_PER_US(2), .QUAL_CYCLES(3), .DETACH_US(5), .SEL_SETUP_CYCLES(4)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .boot_i(boot_i), .image_sel_i(image_sel_i),
      .busy_o(busy0), .usb_detach_o(det0), .warmboot_s_o(s0), .warmboot_boot_o(wb0));

   boot_seq #(.CLK_PERIODS_PER_US(2), .QUAL_CYCLES(1), .DETACH_US(5), .SEL_SETUP_CYCLES(4)) dut1 (
      .clk_i(clk), .rstn_i(rstn_i), .boot_i(boot1_i), .image_sel_i(image_sel_i),
      .busy_o(busy1), .usb_detach_o(det1), .warmboot_s_o(s1), .warmboot_boot_o(wb1));

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   always @(negedge clk) if (mon_en) begin
      cur0 = {busy0, det0, s0, wb0};
      if (cur0 !== prev0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out0_unexpected: got %b expected %b (edge %0d)", cur0, prev0, edge_n);
         end else begin
            ev0 = q0.pop_front();
            chk("out0_val", 32'(cur0), 32'(ev0.v));
            chk("out0_edge", edge_n, ev0.e);
         end
         prev0 = cur0;
      end
   end

   always @(negedge clk) if (mon_en) begin
      cur1 = {busy1, det1, s1, wb1};
      if (cur1 !== prev1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL out1_unexpected: got %b expected %b (edge %0d)", cur1, prev1, edge_n);
         end else begin
            ev1 = q1.pop_front();
            chk("out1_val", 32'(cur1), 32'(ev1.v));
            chk("out1_edge", edge_n, ev1.e);
         end
         prev1 = cur1;
      end
   end

   task automatic exp0(input int ed, input logic [4:0] v);
      q0.push_back('{e: ed, v: v});
   endtask

   task automatic exp1(input int ed, input logic [4:0] v);
      q1.push_back('{e: ed, v: v});
   endtask

   // boot_i high from edge ed onwards with QUAL_CYCLES=3: commit at ed+2, select at ed+12, BOOT at ed+16
   task automatic push_nom(input int ed, input logic [1:0] s);
      exp0(ed + 2, 5'b11000);
      exp0(ed + 12, {2'b11, s, 1'b0});
      exp0(ed + 16, {2'b11, s, 1'b1});
   endtask

   task automatic do_reset(input bit act0, input bit act1);
      @(posedge clk);
      #2;
      if (act0) exp0(edge_n, 5'b00000);
      if (act1) exp1(edge_n, 5'b00000);
      rstn_i = 1'b0;
      #1;
      chk("rst_async_out0", 32'({busy0, det0, s0, wb0}), 32'd0);
      chk("rst_async_out1", 32'({busy1, det1, s1, wb1}), 32'd0);
      @(negedge clk);
      rstn_i = 1'b1;
   endtask

   bit pat[5]  = '{1, 0, 1, 1, 0};
   int expq[5] = '{1, 0, 1, 2, 0};

   initial begin
      #1 rstn_i = 1'b0;
      #1;
      chk("reset_out0", 32'({busy0, det0, s0, wb0}), 32'd0);
      chk("reset_out1", 32'({busy1, det1, s1, wb1}), 32'd0);
      image_sel_i = 2'b11;
      repeat (2) @(negedge clk);
      chk("reset_hold_out0", 32'({busy0, det0, s0, wb0}), 32'd0);
      chk("reset_qual", 32'(dut.qual_cnt_q), 32'd0);
      rstn_i = 1'b1;
      mon_en = 1'b1;
      // nominal boot, held in ST_BOOT while boot_i stays high
      @(negedge clk);
      image_sel_i = 2'b01; boot_i = 1'b1; e = edge_n + 1;
      push_nom(e, 2'b01);
      repeat (25) @(negedge clk);
      chk("nominal_held", 32'({busy0, det0, s0, wb0}), 32'b11011);
      boot_i = 1'b0;
      do_reset(1'b1, 1'b0);
      // glitch reject: pulses of 1 and 2 samples
      @(negedge clk);
      boot_i = pat[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("glitch_qual", 32'(dut.qual_cnt_q), expq[i]);
         boot_i = (i < 4) ? pat[i + 1] : 1'b0;
      end
      repeat (5) @(negedge clk);
      chk("glitch_out", 32'({busy0, det0, s0, wb0}), 32'd0);
      // select latched on the commit edge only
      image_sel_i = 2'b01; boot_i = 1'b1; e = edge_n + 1;
      push_nom(e, 2'b10);
      @(negedge clk);
      @(negedge clk);
      image_sel_i = 2'b10;
      @(negedge clk);
      image_sel_i = 2'b11;
      repeat (20) @(negedge clk);
      boot_i = 1'b0;
      do_reset(1'b1, 1'b0);
      // no abort after commit
      @(negedge clk);
      image_sel_i = 2'b11; boot_i = 1'b1; e = edge_n + 1;
      push_nom(e, 2'b11);
      repeat (3) @(negedge clk);
      boot_i = 1'b0; image_sel_i = 2'b00;
      repeat (20) @(negedge clk);
      do_reset(1'b1, 1'b0);
      // reset during ST_SETUP, then a fresh request
      @(negedge clk);
      image_sel_i = 2'b01; boot_i = 1'b1; e = edge_n + 1;
      exp0(e + 2, 5'b11000);
      exp0(e + 12, 5'b11010);
      repeat (3) @(negedge clk);
      boot_i = 1'b0;
      repeat (11) @(negedge clk);
      do_reset(1'b1, 1'b0);
      @(negedge clk);
      image_sel_i = 2'b10; boot_i = 1'b1; e = edge_n + 1;
      push_nom(e, 2'b10);
      repeat (3) @(negedge clk);
      boot_i = 1'b0;
      repeat (18) @(negedge clk);
      chk("fresh_boot", 32'({busy0, det0, s0, wb0}), 32'b11101);
      do_reset(1'b1, 1'b0);
      // QUAL_CYCLES=1 build commits on a single sample
      @(negedge clk);
      image_sel_i = 2'b11; boot1_i = 1'b1; e = edge_n + 1;
      exp1(e, 5'b11000);
      exp1(e + 10, 5'b11110);
      exp1(e + 14, 5'b11111);
      @(negedge clk);
      boot1_i = 1'b0;
      repeat (20) @(negedge clk);
      do_reset(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
